// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - valid/ready payload interface feeding the UART transmitter FIFO
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter with input FIFO and back-to-back framing
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_FRQ    = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               in_if,
  output logic                        tx,
  output logic                        busy,
  output logic                        done_tx,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int BAUD_DIV = CLK_FRQ / BAUD_RATE;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int LW       = PW + 1;
  localparam int IW       = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter set");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level_nx;
  logic                 in_ready_q;
  logic                 push, pop, empty;

  logic [2:0]           state, state_nx;
  logic [CW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, data_last, stop_last, frame_end;
  logic                 tx_nx, done_nx;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign in_if.in_ready = in_ready_q;
  assign empty     = (level == '0);
  assign push      = in_if.in_valid && in_ready_q;
  assign tick      = (baud_cnt == CW'(BAUD_DIV - 1));
  assign data_last = (bit_idx == IW'(DATA_BITS - 1));
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_end = (state == S_STOP) && tick && stop_last;
  // A pop both leaves IDLE and chains the next frame straight out of the last stop cycle.
  assign pop       = !empty && ((state == S_IDLE) || frame_end);
  assign level_nx  = level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!empty) state_nx = S_START;
      S_START:  if (tick) state_nx = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (tick && data_last) state_nx = S_PARITY;
      S_PARITY: if (tick) state_nx = S_STOP;
`else
      S_DATA:   if (tick && data_last) state_nx = S_STOP;
`endif
      S_STOP:   if (frame_end) state_nx = empty ? S_IDLE : S_START;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Next value of the registered line; tx changes only at bit boundaries.
  always_comb begin
    tx_nx   = tx;
    done_nx = 1'b0;
    case (state)
      S_IDLE:  tx_nx = empty;
      S_START: if (tick) tx_nx = shreg[0];
      S_DATA: begin
        if (tick) begin
`ifdef UART_TX_PARITY_EN
          tx_nx = data_last ? par_bit : shreg[1];
`else
          tx_nx = data_last ? 1'b1 : shreg[1];
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (tick) tx_nx = 1'b1;
`endif
      S_STOP: begin
        if (frame_end) begin
          done_nx = 1'b1;
          tx_nx   = empty;
        end
      end
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_if.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx         <= 1'b1;
      done_tx    <= 1'b0;
      busy       <= 1'b0;
      level      <= '0;
      in_ready_q <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      tx         <= tx_nx;
      done_tx    <= done_nx;
      level      <= level_nx;
      in_ready_q <= (level_nx != LW'(FIFO_DEPTH));
      busy       <= (state_nx != S_IDLE) || (level_nx != '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (pop || tick || state_nx == S_IDLE) baud_cnt <= '0;
      else                                   baud_cnt <= baud_cnt + 1'b1;

      if (pop) begin
        shreg   <= mem[rd_ptr];
        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        par_bit <= (^mem[rd_ptr]) ^ PARITY_ODD[0];
`endif
      end else if (state == S_DATA && tick) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end

      if (state != S_STOP || frame_end) stop_cnt <= 1'b0;
      else if (tick)                    stop_cnt <= stop_cnt + 1'b1;
    end
  end
endmodule
